// File: rtl/soc_decerr_slave.sv
// soc_decerr_slave: AXI default slave that answers DECERR.
// Catches every AW/W/AR routed outside the peripheral map.
//
// Write side: AW -> W beats (ignored) -> one B with DECERR.
// Read side : AR -> ar_len_i+1 R beats of RESP_DATA, DECERR.
// The write and read FSMs are independent; each keeps at most
// one transaction outstanding.
//
// Ports
//   clk_i, rst_i      clock, sync active-high reset
//   aw_*              write address (valid/ready/id)
//   w_*               write data (valid/ready/last only)
//   b_*               write response (valid/ready/id/resp)
//   ar_*              read address (valid/ready/id/len)
//   r_*               read data (valid/ready/id/data/resp/last)
module soc_decerr_slave #(
  parameter int ID_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] RESP_DATA =
    64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  aw_valid_i,
  output logic                  aw_ready_o,
  input  logic [ID_WIDTH-1:0]   aw_id_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic                  w_last_i,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  output logic [ID_WIDTH-1:0]   b_id_o,
  output logic [1:0]            b_resp_o,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [ID_WIDTH-1:0]   ar_id_i,
  input  logic [7:0]            ar_len_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o
);

  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  w_state_e            w_state_q, w_state_d;
  logic                aw_ready_q, aw_ready_d;
  logic                w_ready_q, w_ready_d;
  logic                b_valid_q, b_valid_d;
  logic [ID_WIDTH-1:0] b_id_q, b_id_d;

  r_state_e            r_state_q, r_state_d;
  logic                ar_ready_q, ar_ready_d;
  logic                r_valid_q, r_valid_d;
  logic                r_last_q, r_last_d;
  logic [ID_WIDTH-1:0] r_id_q, r_id_d;
  logic [7:0]          cnt_q, cnt_d;

  // Write FSM. Ready comes back one cycle after reset
  // because all handshake outputs are registered.
  always_comb begin
    w_state_d  = w_state_q;
    aw_ready_d = aw_ready_q;
    w_ready_d  = w_ready_q;
    b_valid_d  = b_valid_q;
    b_id_d     = b_id_q;
    unique case (w_state_q)
      W_IDLE: begin
        aw_ready_d = 1'b1;
        if (aw_valid_i && aw_ready_q) begin
          aw_ready_d = 1'b0;
          w_ready_d  = 1'b1;
          b_id_d     = aw_id_i;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (w_valid_i && w_ready_q && w_last_i) begin
          w_ready_d = 1'b0;
          b_valid_d = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_ready_i && b_valid_q) begin
          b_valid_d  = 1'b0;
          aw_ready_d = 1'b1;
          w_state_d  = W_IDLE;
        end
      end
      default: begin
        aw_ready_d = 1'b0;
        w_ready_d  = 1'b0;
        b_valid_d  = 1'b0;
        w_state_d  = W_IDLE;
      end
    endcase
  end

  // Read FSM. r_last is precomputed so it is a flop output:
  // it rises on the beat after the one seen with cnt==1.
  always_comb begin
    r_state_d  = r_state_q;
    ar_ready_d = ar_ready_q;
    r_valid_d  = r_valid_q;
    r_last_d   = r_last_q;
    r_id_d     = r_id_q;
    cnt_d      = cnt_q;
    unique case (r_state_q)
      R_IDLE: begin
        ar_ready_d = 1'b1;
        if (ar_valid_i && ar_ready_q) begin
          ar_ready_d = 1'b0;
          r_valid_d  = 1'b1;
          r_id_d     = ar_id_i;
          cnt_d      = ar_len_i;
          r_last_d   = (ar_len_i == 8'd0);
          r_state_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (r_ready_i && r_valid_q) begin
          if (r_last_q) begin
            r_valid_d  = 1'b0;
            r_last_d   = 1'b0;
            ar_ready_d = 1'b1;
            r_state_d  = R_IDLE;
          end else begin
            cnt_d    = cnt_q - 8'd1;
            r_last_d = (cnt_q == 8'd1);
          end
        end
      end
      default: begin
        ar_ready_d = 1'b0;
        r_valid_d  = 1'b0;
        r_last_d   = 1'b0;
        r_state_d  = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q  <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_id_q     <= '0;
      cnt_q      <= 8'd0;
    end else begin
      w_state_q  <= w_state_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_id_q     <= b_id_d;
      r_state_q  <= r_state_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_last_q   <= r_last_d;
      r_id_q     <= r_id_d;
      cnt_q      <= cnt_d;
    end
  end

  assign aw_ready_o = aw_ready_q;
  assign w_ready_o  = w_ready_q;
  assign b_valid_o  = b_valid_q;
  assign b_id_o     = b_id_q;
  assign b_resp_o   = DECERR;
  assign ar_ready_o = ar_ready_q;
  assign r_valid_o  = r_valid_q;
  assign r_last_o   = r_last_q;
  assign r_id_o     = r_id_q;
  assign r_data_o   = RESP_DATA;
  assign r_resp_o   = DECERR;

endmodule

// File: tb/tb_soc_decerr_slave.sv
// tb_soc_decerr_slave: directed bench for soc_decerr_slave.
// Hand-computed expectations, all checks through chk().
module tb_soc_decerr_slave;

  localparam logic [63:0] DATA = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        aw_valid = 1'b0;
  logic        aw_ready;
  logic [4:0]  aw_id = '0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic        w_last = 1'b0;
  logic        b_valid;
  logic        b_ready = 1'b0;
  logic [4:0]  b_id;
  logic [1:0]  b_resp;
  logic        ar_valid = 1'b0;
  logic        ar_ready;
  logic [4:0]  ar_id = '0;
  logic [7:0]  ar_len = '0;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [4:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  soc_decerr_slave dut (
    .clk_i(clk),
    .rst_i(rst),
    .aw_valid_i(aw_valid),
    .aw_ready_o(aw_ready),
    .aw_id_i(aw_id),
    .w_valid_i(w_valid),
    .w_ready_o(w_ready),
    .w_last_i(w_last),
    .b_valid_o(b_valid),
    .b_ready_i(b_ready),
    .b_id_o(b_id),
    .b_resp_o(b_resp),
    .ar_valid_i(ar_valid),
    .ar_ready_o(ar_ready),
    .ar_id_i(ar_id),
    .ar_len_i(ar_len),
    .r_valid_o(r_valid),
    .r_ready_i(r_ready),
    .r_id_o(r_id),
    .r_data_o(r_data),
    .r_resp_o(r_resp),
    .r_last_o(r_last)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int r_beats, r_lasts, last_at, b_hs, b_cyc, w_hs_n;
  logic w_hs;

  initial begin
    // reset
    tick();
    tick();
    chk("rst_aw_ready", 64'(aw_ready), 0);
    chk("rst_ar_ready", 64'(ar_ready), 0);
    chk("rst_w_ready", 64'(w_ready), 0);
    chk("rst_b_valid", 64'(b_valid), 0);
    chk("rst_r_valid", 64'(r_valid), 0);
    chk("rst_b_id", 64'(b_id), 0);
    chk("rst_r_id", 64'(r_id), 0);
    rst = 1'b0;
    tick();
    chk("post_aw_ready", 64'(aw_ready), 1);
    chk("post_ar_ready", 64'(ar_ready), 1);
    chk("post_w_ready", 64'(w_ready), 0);
    chk("post_b_valid", 64'(b_valid), 0);
    chk("post_r_valid", 64'(r_valid), 0);
    chk("post_r_last", 64'(r_last), 0);

    // W before AW is refused
    w_valid = 1'b1;
    w_last = 1'b0;
    b_ready = 1'b1;
    tick();
    chk("early_w_ready", 64'(w_ready), 0);
    tick();
    chk("early_w_ready2", 64'(w_ready), 0);

    // AW id 0x13, then 4 beats
    aw_valid = 1'b1;
    aw_id = 5'h13;
    tick();
    aw_valid = 1'b0;
    aw_id = 5'h00;
    chk("wdata_aw_ready", 64'(aw_ready), 0);
    chk("wdata_w_ready", 64'(w_ready), 1);
    for (int i = 0; i < 4; i++) begin
      w_last = (i == 3);
      tick();
      if (i < 3) chk("wbeat_no_b", 64'(b_valid), 0);
    end
    w_valid = 1'b0;
    w_last = 1'b0;
    chk("b_valid", 64'(b_valid), 1);
    chk("b_id", 64'(b_id), 64'h13);
    chk("b_resp", 64'(b_resp), 3);
    chk("b_w_ready", 64'(w_ready), 0);
    tick();
    chk("b_done", 64'(b_valid), 0);
    chk("b_aw_ready", 64'(aw_ready), 1);
    chk("b_id_hold", 64'(b_id), 64'h13);

    // AR id 7 len 3
    r_ready = 1'b1;
    ar_valid = 1'b1;
    ar_id = 5'h07;
    ar_len = 8'd3;
    tick();
    ar_valid = 1'b0;
    chk("rd_ar_ready", 64'(ar_ready), 0);
    for (int i = 0; i < 4; i++) begin
      chk("rd_valid", 64'(r_valid), 1);
      chk("rd_last", 64'(r_last), (i == 3) ? 1 : 0);
      chk("rd_id", 64'(r_id), 64'h07);
      chk("rd_data", r_data, DATA);
      chk("rd_resp", 64'(r_resp), 3);
      tick();
    end
    chk("rd_end_valid", 64'(r_valid), 0);
    chk("rd_end_ar_ready", 64'(ar_ready), 1);

    // AR len 0 with backpressure
    r_ready = 1'b0;
    ar_valid = 1'b1;
    ar_id = 5'h0A;
    ar_len = 8'd0;
    tick();
    ar_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 64'(r_valid), 1);
      chk("bp_last", 64'(r_last), 1);
      chk("bp_id", 64'(r_id), 64'h0A);
      chk("bp_data", r_data, DATA);
      r_ready = (i == 2);
      tick();
    end
    chk("bp_done", 64'(r_valid), 0);

    // len 255 read concurrent with a 1-beat write
    r_ready = 1'b1;
    b_ready = 1'b1;
    ar_valid = 1'b1;
    ar_id = 5'h02;
    ar_len = 8'd255;
    aw_valid = 1'b1;
    aw_id = 5'h04;
    w_valid = 1'b1;
    w_last = 1'b1;
    tick();
    ar_valid = 1'b0;
    aw_valid = 1'b0;
    r_beats = 0;
    r_lasts = 0;
    last_at = -1;
    b_hs = 0;
    b_cyc = -1;
    w_hs_n = 0;
    for (int c = 0; c < 270; c++) begin
      if (r_valid && r_ready) begin
        r_beats++;
        if (r_last) begin
          r_lasts++;
          last_at = r_beats;
        end
      end
      if (b_valid && b_ready) begin
        b_hs++;
        b_cyc = c;
        chk("cc_b_id", 64'(b_id), 64'h04);
      end
      w_hs = w_valid && w_ready;
      if (w_hs) w_hs_n++;
      tick();
      if (w_hs) begin
        w_valid = 1'b0;
        w_last = 1'b0;
      end
    end
    chk("cc_r_beats", 64'(r_beats), 256);
    chk("cc_r_lasts", 64'(r_lasts), 1);
    chk("cc_last_at", 64'(last_at), 256);
    chk("cc_w_beats", 64'(w_hs_n), 1);
    chk("cc_b_count", 64'(b_hs), 1);
    chk("cc_b_cycle", 64'(b_cyc), 1);
    chk("cc_ar_ready", 64'(ar_ready), 1);

    // reset mid-burst
    ar_valid = 1'b1;
    ar_id = 5'h03;
    ar_len = 8'd7;
    tick();
    ar_valid = 1'b0;
    tick();
    tick();
    chk("mid_valid", 64'(r_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", 64'(r_valid), 0);
    chk("mrst_last", 64'(r_last), 0);
    chk("mrst_r_id", 64'(r_id), 0);
    tick();
    chk("mrst_valid2", 64'(r_valid), 0);
    chk("mrst_ar_ready", 64'(ar_ready), 1);
    chk("mrst_aw_ready", 64'(aw_ready), 1);
    ar_valid = 1'b1;
    ar_id = 5'h01;
    ar_len = 8'd0;
    tick();
    ar_valid = 1'b0;
    chk("new_valid", 64'(r_valid), 1);
    chk("new_last", 64'(r_last), 1);
    chk("new_id", 64'(r_id), 64'h01);
    tick();
    chk("new_done", 64'(r_valid), 0);
    tick();
    chk("new_quiet", 64'(r_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_decerr_slave.md
SOC_DECERR_SLAVE -- requirements
Module: soc_decerr_slave

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 5, meaning AXI ID width on the crossbar slave side (4 master ID bits plus 1 bit for 2 masters).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning R data width.
REQ-003 SHALL have parameter RESP_DATA, default 64'hDEAD_BEEF_DEAD_BEEF, meaning the constant returned on r_data_o.
REQ-004 SHALL have port clk_i, input, 1, meaning the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, meaning reset; it is synchronous and active-high.
REQ-006 SHALL have ports aw_valid_i in 1, aw_ready_o out 1, aw_id_i in ID_WIDTH, meaning the write address channel.
REQ-007 SHALL have ports w_valid_i in 1, w_ready_o out 1, w_last_i in 1, meaning the write data channel (data and strobe are ignored and not ported).
REQ-008 SHALL have ports b_valid_o out 1, b_ready_i in 1, b_id_o out ID_WIDTH, b_resp_o out 2, meaning the write response channel.
REQ-009 SHALL have ports ar_valid_i in 1, ar_ready_o out 1, ar_id_i in ID_WIDTH, ar_len_i in 8, meaning the read address channel.
REQ-010 SHALL have ports r_valid_o out 1, r_ready_i in 1, r_id_o out ID_WIDTH, r_data_o out DATA_WIDTH, r_resp_o out 2, r_last_o out 1, meaning the read data channel.

Function
REQ-011 SHALL terminate every transaction the crossbar routes to addresses outside the peripheral map (the map ends at DRAM base 0x8000_0000 + 1 GiB), with response DECERR (2'b11).
REQ-012 SHALL run the write FSM and the read FSM independently; activity on one SHALL never stall the other.
REQ-013 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP.
REQ-014 W_IDLE: aw_ready_o=1; on aw_valid_i, capture aw_id_i and go to W_DATA.
REQ-015 W_DATA: w_ready_o=1 and aw_ready_o=0; each w_valid_i beat is consumed; a beat with w_last_i=1 moves to W_RESP on the next cycle.
REQ-016 W_RESP: b_valid_o=1, b_id_o=captured ID, b_resp_o=2'b11; on b_ready_i, return to W_IDLE.
REQ-017 W beats arriving before AW are not accepted (w_ready_o=0 outside W_DATA).
REQ-018 Read FSM SHALL have states R_IDLE and R_DATA.
REQ-019 R_IDLE: ar_ready_o=1; on ar_valid_i, capture ar_id_i, load the 8-bit beat counter with ar_len_i, and go to R_DATA.
REQ-020 R_DATA: r_valid_o=1, r_id_o=captured ID, r_data_o=RESP_DATA, r_resp_o=2'b11, r_last_o=1 exactly when counter==0.
REQ-021 Each r_valid_o && r_ready_i handshake SHALL decrement the counter; the handshake with r_last_o=1 SHALL return to R_IDLE.
REQ-022 ar_len_i=255 SHALL produce exactly 256 beats; the counter SHALL never wrap below 0.
REQ-023 Once asserted, valid outputs and their payloads SHALL hold stable until the handshake completes (AXI rule).
REQ-024 At most one write and one read SHALL be outstanding; AW/AR SHALL be refused (ready=0) until the current transaction completes, so back-to-back requests are spaced by at least one idle cycle.
REQ-025 Outputs other than ready/valid/last SHALL hold their last captured values; b_resp_o and r_resp_o SHALL be constant 2'b11.

Reset
REQ-026 While rst_i=1 at a clock edge, both FSMs SHALL go to their idle state, captured IDs and the counter SHALL clear to 0, and all valid and ready outputs SHALL be 0.
REQ-027 In the first cycle after rst_i deasserts, aw_ready_o=1, ar_ready_o=1, w_ready_o=0, b_valid_o=0, r_valid_o=0, r_last_o=0.
REQ-028 Reset asserted mid-burst SHALL abandon the transaction with no further beats or responses issued.

Verification
REQ-029 AW id=5'h13, then 4 W beats (last on 4th), b_ready_i=1 -> single B, b_id_o=5'h13, b_resp_o=2'b11, one cycle after the last W handshake.
REQ-030 AR id=5'h07, len=3, r_ready_i=1 -> 4 consecutive R beats, data RESP_DATA, resp 2'b11, r_last_o only on the 4th, then ar_ready_o=1.
REQ-031 AR len=0 with r_ready_i toggling 0,0,1 -> r_valid_o held for 3 cycles with stable payload, r_last_o=1, single beat.
REQ-032 AR len=255 concurrent with an AW + 1-beat write -> 256 R beats and one B, both independent, neither channel stalled.
REQ-033 W beat offered while in W_IDLE -> w_ready_o=0 until AW is accepted.
REQ-034 rst_i pulsed after 2 of 8 R beats -> r_valid_o=0 from the next cycle; a new AR id=5'h01 len=0 then yields exactly one beat with r_last_o=1.
